mem_agu: RTL and testbench

Parametrised memory address-generation and access unit between issue and commit. It accepts one load/store op from the issue stage and computes the effective address (base + sign-extended offset). It then runs a single outstanding access against the data-cache request/response interface and returns a sign/zero-extended load result, or a store completion, to commit. It adds flush-safe draining of in-flight cache responses, an alignment exception path, and byte-lane write strobes.

---
 rtl/mem_agu.sv | 185 ++++++++++++++++++
 tb/tb_mem_agu.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_agu.sv
// mem_agu: single-outstanding load/store address generation and data-cache access unit.
// Define AGU_MISALIGN_CHECK_EN to compile in alignment exceptions; otherwise addresses are forced aligned.
module mem_agu #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 16,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [2:0]        in_op,
  input  logic              in_uns,
  input  logic [31:0]       in_wdata,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              dc_req,
  output logic              dc_wr,
  output logic [1:0]        dc_size,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [31:0]       dc_wdata,
  output logic [3:0]        dc_wstrb,
  input  logic              dc_addr_ok,
  input  logic              dc_data_ok,
  input  logic [31:0]       dc_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [1:0]        out_exc
);

  typedef enum logic [2:0] {IDLE, ADDR, REQUEST, RESPONSE, DONE, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   base_reg;
  logic [OFF_W-1:0]    off_reg;
  logic [2:0]          op_reg;
  logic                uns_reg;
  logic [31:0]         wdata_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [ADDR_W-1:0]   ea_reg;
  logic [3:0]          strb_reg;
  logic [31:0]         dwdata_reg;
  logic [31:0]         out_data_reg;

  logic                accept;
  logic [ADDR_W-1:0]   ea_raw, ea_calc;
  logic                addr_bad;
  logic [3:0]          strb_calc;
  logic [31:0]         wlane;
  logic [31:0]         rshift, load_ext;

  assign accept = in_valid & in_ready;
  assign ea_raw = base_reg + {{(ADDR_W-OFF_W){off_reg[OFF_W-1]}}, off_reg};

`ifdef AGU_MISALIGN_CHECK_EN
  logic [1:0] exc_reg;
  assign ea_calc  = ea_raw;
  assign addr_bad = ((op_reg[1:0] == 2'd1) & ea_raw[0]) | (op_reg[1] & (ea_raw[1:0] != 2'b00));
  assign out_exc  = exc_reg;
`else
  // Without exceptions the low address bits are simply dropped so every op reaches the cache.
  assign ea_calc  = op_reg[1] ? {ea_raw[ADDR_W-1:2], 2'b00} :
                    op_reg[0] ? {ea_raw[ADDR_W-1:1], 1'b0} : ea_raw;
  assign addr_bad = 1'b0;
  assign out_exc  = 2'b00;
`endif

  always_comb begin
    case (op_reg[1:0])
      2'd0:    strb_calc = 4'b0001 << ea_calc[1:0];
      2'd1:    strb_calc = 4'b0011 << ea_calc[1:0];
      default: strb_calc = 4'b1111;
    endcase
  end

  // Each byte lane picks the store byte that lands on it for the access size.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wlane[gi*8 +: 8] = (op_reg[1:0] == 2'd0) ? wdata_reg[7:0] :
                                (op_reg[1:0] == 2'd1) ? wdata_reg[(gi%2)*8 +: 8] :
                                                        wdata_reg[gi*8 +: 8];
    end
  endgenerate

  assign rshift = dc_rdata >> {ea_reg[1:0], 3'b000};

  always_comb begin
    case (op_reg[1:0])
      2'd0:    load_ext = uns_reg ? {24'd0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'd1:    load_ext = uns_reg ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept) state_next = ADDR;
      ADDR:     if (flush) state_next = IDLE;
                else if (addr_bad) state_next = DONE;
                else state_next = REQUEST;
      REQUEST:  if (flush) state_next = dc_addr_ok ? DRAIN : IDLE;
                else if (dc_addr_ok) state_next = RESPONSE;
      RESPONSE: if (flush) state_next = dc_data_ok ? IDLE : DRAIN;
                else if (dc_data_ok) state_next = DONE;
      DONE:     if (flush || out_ready) state_next = IDLE;
      DRAIN:    if (dc_data_ok) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    dc_req    = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = reset & ~flush;
      REQUEST: dc_req    = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_reg     <= '0;
      off_reg      <= '0;
      op_reg       <= '0;
      uns_reg      <= 1'b0;
      wdata_reg    <= '0;
      tag_reg      <= '0;
      ea_reg       <= '0;
      strb_reg     <= '0;
      dwdata_reg   <= '0;
      out_data_reg <= '0;
`ifdef AGU_MISALIGN_CHECK_EN
      exc_reg      <= 2'b00;
`endif
    end else begin
      if (accept) begin
        base_reg     <= in_base;
        off_reg      <= in_offset;
        op_reg       <= in_op;
        uns_reg      <= in_uns;
        wdata_reg    <= in_wdata;
        tag_reg      <= in_tag;
        out_data_reg <= '0;
`ifdef AGU_MISALIGN_CHECK_EN
        exc_reg      <= 2'b00;
`endif
      end
      if (state_reg == ADDR) begin
        ea_reg     <= ea_calc;
        strb_reg   <= (op_reg[2] && !addr_bad) ? strb_calc : 4'b0000;
        dwdata_reg <= op_reg[2] ? wlane : 32'd0;
`ifdef AGU_MISALIGN_CHECK_EN
        exc_reg    <= addr_bad ? (op_reg[2] ? 2'b10 : 2'b01) : 2'b00;
`endif
      end
      if (state_reg == RESPONSE && dc_data_ok)
        out_data_reg <= op_reg[2] ? 32'd0 : load_ext;
    end
  end

  assign dc_wr    = op_reg[2];
  assign dc_size  = op_reg[1:0];
  assign dc_addr  = ea_reg;
  assign dc_wdata = dwdata_reg;
  assign dc_wstrb = strb_reg;
  assign out_tag  = tag_reg;
  assign out_addr = ea_reg;
  assign out_data = out_data_reg;

endmodule

// File: tb/tb_mem_agu.sv
// Self-checking bench for mem_agu: directed scenarios plus randomized ops against an arithmetic reference model.
module tb_mem_agu;

  logic        clk, reset, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_base;
  logic [15:0] in_offset;
  logic [2:0]  in_op;
  logic        in_uns;
  logic [31:0] in_wdata;
  logic [5:0]  in_tag;
  logic        dc_req, dc_wr;
  logic [1:0]  dc_size;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        dc_addr_ok, dc_data_ok;
  logic [31:0] dc_rdata;
  logic        out_valid, out_ready;
  logic [5:0]  out_tag;
  logic [31:0] out_addr, out_data;
  logic [1:0]  out_exc;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AGU_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  mem_agu #(.ADDR_W(32), .OFF_W(16), .TAG_W(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_base(in_base), .in_offset(in_offset),
    .in_op(in_op), .in_uns(in_uns), .in_wdata(in_wdata), .in_tag(in_tag),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_size(dc_size), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_addr_ok(dc_addr_ok),
    .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_addr(out_addr), .out_data(out_data), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations captured by do_op for one complete transaction.
  int          obs_req_first, obs_req_cnt, obs_out_first, obs_out_cnt;
  bit          obs_req_unstable, obs_out_unstable, obs_timeout;
  logic        obs_after_valid, obs_after_ready;
  logic        obs_wr;
  logic [1:0]  obs_size;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_strb;
  logic [5:0]  obs_tag;
  logic [31:0] obs_oaddr, obs_odata;
  logic [1:0]  obs_exc;

  task automatic tick;
    @(negedge clk);
    in_valid = 1'b0; dc_addr_ok = 1'b0; dc_data_ok = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic issue(input logic [31:0] base, input logic [15:0] off, input logic [2:0] op,
                       input logic uns, input logic [31:0] wdata, input logic [5:0] tag);
    tick();
    in_valid = 1'b1; in_base = base; in_offset = off; in_op = op; in_uns = uns;
    in_wdata = wdata; in_tag = tag;
    #1;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: got %b want 1", in_ready); end
    n_checks++;
  endtask

  // Drives one op and plays a cache / commit stage with the given wait counts.
  task automatic do_op(input logic [31:0] base, input logic [15:0] off, input logic [2:0] op,
                       input logic uns, input logic [31:0] wdata, input logic [5:0] tag,
                       input logic [31:0] rdata, input int aw, input int dw, input int ow);
    int  wait_cnt;
    int  resp;
    bit  accepted;
    bit  done;
    obs_req_first = -1; obs_req_cnt = 0; obs_out_first = -1; obs_out_cnt = 0;
    obs_req_unstable = 0; obs_out_unstable = 0; obs_timeout = 0;
    tick();
    in_valid = 1'b1; in_base = base; in_offset = off; in_op = op; in_uns = uns;
    in_wdata = wdata; in_tag = tag;
    #1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin @(negedge clk); #1; wait_cnt++; end
    if (!in_ready) begin obs_timeout = 1; in_valid = 1'b0; return; end
    accepted = 0; done = 0; resp = 0;
    for (int c = 1; c <= 80 && !done; c++) begin
      @(negedge clk);
      in_valid = 1'b0; dc_addr_ok = 1'b0; dc_data_ok = 1'b0; out_ready = 1'b0; dc_rdata = ~rdata;
      #1;
      if (accepted) begin
        resp++;
        if (resp > dw) begin dc_data_ok = 1'b1; dc_rdata = rdata; accepted = 0; end
      end
      if (dc_req) begin
        obs_req_cnt++;
        if (obs_req_cnt == 1) begin
          obs_req_first = c; obs_wr = dc_wr; obs_size = dc_size; obs_addr = dc_addr;
          obs_wdata = dc_wdata; obs_strb = dc_wstrb;
        end else if ({dc_wr, dc_size, dc_addr, dc_wdata, dc_wstrb} !==
                     {obs_wr, obs_size, obs_addr, obs_wdata, obs_strb}) obs_req_unstable = 1;
        if (obs_req_cnt > aw) begin dc_addr_ok = 1'b1; accepted = 1; resp = 0; end
      end
      if (out_valid) begin
        obs_out_cnt++;
        if (obs_out_cnt == 1) begin
          obs_out_first = c; obs_tag = out_tag; obs_oaddr = out_addr; obs_odata = out_data;
          obs_exc = out_exc;
        end else if ({out_tag, out_addr, out_data, out_exc} !==
                     {obs_tag, obs_oaddr, obs_odata, obs_exc}) obs_out_unstable = 1;
        if (obs_out_cnt > ow) begin out_ready = 1'b1; done = 1; end
      end
    end
    if (!done) obs_timeout = 1;
    tick();
    #1;
    obs_after_valid = out_valid;
    obs_after_ready = in_ready;
  endtask

  // Reference model: plain arithmetic on byte offsets and sizes.
  task automatic ref_model(input logic [31:0] base, input logic [15:0] off, input logic [2:0] op,
                           input logic uns, input logic [31:0] wdata, input logic [31:0] rdata,
                           output logic [31:0] ea, output bit bad, output logic [3:0] strb,
                           output logic [31:0] dw, output logic [31:0] res);
    longint e, v, nb, ofs;
    nb  = longint'(1) << op[1:0];
    e   = (longint'(base) + longint'($signed(off))) & 64'hFFFF_FFFF;
    bad = CHECK_EN && (e % nb != 0);
    if (!CHECK_EN) e = e - (e % nb);
    ofs = e % 4;
    ea  = e[31:0];
    strb = 4'b0000;
    dw   = 32'd0;
    res  = 32'd0;
    if (op[2] && !bad)
      for (int k = 0; k < nb; k++) strb[ofs + k] = 1'b1;
    for (int i = 0; i < 4; i++) dw[i*8 +: 8] = wdata[(i % nb)*8 +: 8];
    if (!op[2] && !bad) begin
      v = (longint'(rdata) >> (8 * ofs)) % (longint'(1) << (8 * nb));
      if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      res = v[31:0];
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; flush = 1'b1; in_valid = 1'b1; dc_addr_ok = 1'b0; dc_data_ok = 1'b0;
    out_ready = 1'b0; dc_rdata = 32'd0; in_base = 32'd0; in_offset = 16'd0; in_op = 3'd0;
    in_uns = 1'b0; in_wdata = 32'd0; in_tag = 6'd0;
    repeat (3) @(negedge clk);
    #1;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++;
    if ({dc_req, dc_wr, dc_size, dc_addr, dc_wdata, dc_wstrb} !== 72'd0) begin
      n_fail++; $display("FAIL reset_dc: got req=%b wr=%b size=%h addr=%h wdata=%h strb=%h want all 0",
                         dc_req, dc_wr, dc_size, dc_addr, dc_wdata, dc_wstrb);
    end
    n_checks++;
    if ({out_valid, out_tag, out_addr, out_data, out_exc} !== 73'd0) begin
      n_fail++; $display("FAIL reset_out: got valid=%b tag=%h addr=%h data=%h exc=%b want all 0",
                         out_valid, out_tag, out_addr, out_data, out_exc);
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    n_checks++;
  endtask

  task automatic test_lw;
    do_op(32'h1000, 16'hFFFC, 3'b010, 1'b0, 32'h0, 6'd5, 32'h12345678, 0, 0, 0);
    if (obs_timeout || obs_req_first != 2) begin n_fail++; $display("FAIL lw_req_cycle: got %0d want 2", obs_req_first); end
    n_checks++;
    if (obs_addr !== 32'h0FFC || obs_strb !== 4'b0000 || obs_wr !== 1'b0) begin
      n_fail++; $display("FAIL lw_dc: got addr=%h strb=%b wr=%b want 00000ffc 0000 0", obs_addr, obs_strb, obs_wr);
    end
    n_checks++;
    if (obs_out_first != 4) begin n_fail++; $display("FAIL lw_out_cycle: got %0d want 4", obs_out_first); end
    n_checks++;
    if (obs_odata !== 32'h12345678 || obs_tag !== 6'd5 || obs_exc !== 2'b00) begin
      n_fail++; $display("FAIL lw_out: got data=%h tag=%0d exc=%b want 12345678 5 00", obs_odata, obs_tag, obs_exc);
    end
    n_checks++;
  endtask

  task automatic test_lb;
    do_op(32'h2000, 16'h0003, 3'b000, 1'b0, 32'h0, 6'd6, 32'h80FFFFFF, 0, 0, 0);
    if (obs_odata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed: got %h want ffffff80", obs_odata); end
    n_checks++;
    do_op(32'h2000, 16'h0003, 3'b000, 1'b1, 32'h0, 6'd7, 32'h80FFFFFF, 0, 0, 0);
    if (obs_odata !== 32'h00000080) begin n_fail++; $display("FAIL lbu: got %h want 00000080", obs_odata); end
    n_checks++;
  endtask

  task automatic test_sh;
    do_op(32'h3000, 16'h0002, 3'b101, 1'b0, 32'h0000ABCD, 6'd8, 32'h5555AAAA, 0, 0, 0);
    if (obs_wr !== 1'b1 || obs_strb !== 4'b1100 || obs_wdata !== 32'hABCDABCD || obs_size !== 2'd1) begin
      n_fail++; $display("FAIL sh_dc: got wr=%b strb=%b wdata=%h size=%0d want 1 1100 abcdabcd 1",
                         obs_wr, obs_strb, obs_wdata, obs_size);
    end
    n_checks++;
    if (obs_odata !== 32'd0 || obs_out_first != 4) begin
      n_fail++; $display("FAIL sh_out: got data=%h cycle=%0d want 0 4", obs_odata, obs_out_first);
    end
    n_checks++;
  endtask

  task automatic test_misalign;
    do_op(32'h4000, 16'h0002, 3'b010, 1'b0, 32'h0, 6'd9, 32'h11223344, 0, 0, 0);
    if (CHECK_EN) begin
      if (obs_req_cnt != 0 || obs_out_first != 2) begin
        n_fail++; $display("FAIL misalign_path: got reqs=%0d out_cycle=%0d want 0 2", obs_req_cnt, obs_out_first);
      end
      n_checks++;
      if (obs_exc !== 2'b01 || obs_oaddr !== 32'h4002) begin
        n_fail++; $display("FAIL misalign_exc: got exc=%b addr=%h want 01 00004002", obs_exc, obs_oaddr);
      end
      n_checks++;
    end else begin
      if (obs_addr !== 32'h4000 || obs_req_cnt != 1) begin
        n_fail++; $display("FAIL misalign_forced: got addr=%h reqs=%0d want 00004000 1", obs_addr, obs_req_cnt);
      end
      n_checks++;
      if (obs_exc !== 2'b00 || obs_odata !== 32'h11223344) begin
        n_fail++; $display("FAIL misalign_forced_out: got exc=%b data=%h want 00 11223344", obs_exc, obs_odata);
      end
      n_checks++;
    end
  endtask

  task automatic test_flush_drain;
    issue(32'h5000, 16'h0000, 3'b010, 1'b0, 32'h0, 6'd10);        // cycle 0
    tick(); #1;                                                    // cycle 1 ADDR
    tick(); #1;                                                    // cycle 2 REQUEST
    if (dc_req !== 1'b1) begin n_fail++; $display("FAIL drain_req: got %b want 1", dc_req); end
    n_checks++;
    dc_addr_ok = 1'b1;
    tick(); flush = 1'b1; #1;                                      // cycle 3 RESPONSE + flush
    for (int c = 4; c <= 6; c++) begin
      tick();
      if (c == 5) flush = 1'b1;
      if (c == 6) dc_data_ok = 1'b1;
      #1;
      if (in_ready !== 1'b0 || dc_req !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL drain_hold_c%0d: got ready=%b req=%b valid=%b want 0 0 0",
                           c, in_ready, dc_req, out_valid);
      end
      n_checks++;
    end
    tick(); #1;                                                    // cycle 7
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_exit: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    n_checks++;
  endtask

  task automatic test_flush_misc;
    // Flush in ADDR: no request follows.
    issue(32'h5100, 16'h0000, 3'b110, 1'b0, 32'h1, 6'd11);
    tick(); flush = 1'b1; #1;
    tick(); #1;
    if (dc_req !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_addr: got req=%b ready=%b want 0 1", dc_req, in_ready);
    end
    n_checks++;
    // Flush in REQUEST with no addr_ok: straight back to IDLE.
    issue(32'h5200, 16'h0000, 3'b010, 1'b0, 32'h0, 6'd12);
    tick(); #1;
    tick(); flush = 1'b1; #1;
    tick(); #1;
    if (dc_req !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_req_noack: got req=%b ready=%b want 0 1", dc_req, in_ready);
    end
    n_checks++;
    // Flush with addr_ok in REQUEST: drains one response.
    issue(32'h5300, 16'h0000, 3'b010, 1'b0, 32'h0, 6'd13);
    tick(); #1;
    tick(); flush = 1'b1; dc_addr_ok = 1'b1; #1;
    tick(); #1;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_req_ack_drain: got ready=%b want 0", in_ready); end
    n_checks++;
    tick(); dc_data_ok = 1'b1; #1;
    tick(); #1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_req_ack_exit: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    n_checks++;
    // Flush in RESPONSE together with data_ok: IDLE, no result.
    issue(32'h5400, 16'h0000, 3'b010, 1'b0, 32'h0, 6'd14);
    tick(); #1;
    tick(); dc_addr_ok = 1'b1; #1;
    tick(); flush = 1'b1; dc_data_ok = 1'b1; #1;
    tick(); #1;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_resp_ack: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    n_checks++;
    // Flush in DONE alongside out_ready.
    issue(32'h5500, 16'h0000, 3'b010, 1'b0, 32'h0, 6'd15);
    tick(); #1;
    tick(); dc_addr_ok = 1'b1; #1;
    tick(); dc_data_ok = 1'b1; #1;
    tick(); #1;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done_valid: got %b want 1", out_valid); end
    n_checks++;
    flush = 1'b1; out_ready = 1'b1;
    tick(); #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_done_exit: got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    n_checks++;
  endtask

  task automatic test_reset_midop;
    issue(32'h7000, 16'h0000, 3'b110, 1'b0, 32'hDEADBEEF, 6'd16);
    tick(); #1;
    tick(); #1;
    if (dc_req !== 1'b1 || dc_wr !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got req=%b wr=%b want 1 1", dc_req, dc_wr);
    end
    n_checks++;
    reset = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    if (dc_req !== 1'b0 || dc_wr !== 1'b0 || dc_wstrb !== 4'b0000 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: got req=%b wr=%b strb=%b ready=%b want 0 0 0000 0",
                         dc_req, dc_wr, dc_wstrb, in_ready);
    end
    n_checks++;
    reset = 1'b1; #1;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_release: got %b want 1", in_ready); end
    n_checks++;
  endtask

  task automatic test_backpressure;
    do_op(32'h6000, 16'h0008, 3'b010, 1'b0, 32'h0, 6'd17, 32'hCAFEF00D, 5, 1, 3);
    if (obs_req_first != 2 || obs_req_cnt != 6 || obs_req_unstable) begin
      n_fail++; $display("FAIL bp_req: got first=%0d count=%0d unstable=%0d want 2 6 0",
                         obs_req_first, obs_req_cnt, obs_req_unstable);
    end
    n_checks++;
    if (obs_out_first != 10 || obs_out_cnt != 4 || obs_out_unstable) begin
      n_fail++; $display("FAIL bp_out: got first=%0d count=%0d unstable=%0d want 10 4 0",
                         obs_out_first, obs_out_cnt, obs_out_unstable);
    end
    n_checks++;
    if (obs_odata !== 32'hCAFEF00D || obs_oaddr !== 32'h6008 || obs_after_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_result: got data=%h addr=%h after_valid=%b want cafef00d 00006008 0",
                         obs_odata, obs_oaddr, obs_after_valid);
    end
    n_checks++;
  endtask

  task automatic test_random;
    logic [31:0] base, wdata, rdata, e_ea, e_dw, e_res;
    logic [15:0] off;
    logic [2:0]  op;
    logic [5:0]  tag;
    logic [3:0]  e_strb;
    logic        uns;
    bit          bad;
    int          aw, dw, ow;
    for (int n = 0; n < 40; n++) begin
      base  = $urandom;
      off   = 16'($urandom);
      op    = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      uns   = 1'($urandom_range(0, 1));
      wdata = $urandom;
      rdata = $urandom;
      tag   = 6'($urandom);
      aw    = $urandom_range(0, 4);
      dw    = $urandom_range(0, 3);
      ow    = $urandom_range(0, 3);
      ref_model(base, off, op, uns, wdata, rdata, e_ea, bad, e_strb, e_dw, e_res);
      do_op(base, off, op, uns, wdata, tag, rdata, aw, dw, ow);
      if (bad) begin
        if (obs_timeout || obs_req_cnt != 0 || obs_out_first != 2 || obs_exc !== (op[2] ? 2'b10 : 2'b01) ||
            obs_oaddr !== e_ea || obs_odata !== 32'd0) begin
          n_fail++; $display("FAIL rnd_exc[%0d]: got reqs=%0d cyc=%0d exc=%b addr=%h data=%h want 0 2 %b %h 0",
                             n, obs_req_cnt, obs_out_first, obs_exc, obs_oaddr, obs_odata,
                             (op[2] ? 2'b10 : 2'b01), e_ea);
        end
        n_checks++;
      end else begin
        if (obs_timeout || obs_req_first != 2 || obs_req_cnt != aw + 1 || obs_req_unstable ||
            obs_addr !== e_ea || obs_wr !== op[2] || obs_size !== op[1:0] || obs_strb !== e_strb ||
            (op[2] && obs_wdata !== e_dw)) begin
          n_fail++; $display("FAIL rnd_req[%0d]: got addr=%h wr=%b size=%0d strb=%b wdata=%h reqs=%0d want %h %b %0d %b %h %0d",
                             n, obs_addr, obs_wr, obs_size, obs_strb, obs_wdata, obs_req_cnt,
                             e_ea, op[2], op[1:0], e_strb, e_dw, aw + 1);
        end
        n_checks++;
        if (obs_out_first != 4 + aw + dw || obs_out_unstable || obs_odata !== e_res ||
            obs_tag !== tag || obs_oaddr !== e_ea || obs_exc !== 2'b00) begin
          n_fail++; $display("FAIL rnd_out[%0d]: got cyc=%0d data=%h tag=%0d addr=%h exc=%b want %0d %h %0d %h 00",
                             n, obs_out_first, obs_odata, obs_tag, obs_oaddr, obs_exc,
                             4 + aw + dw, e_res, tag, e_ea);
        end
        n_checks++;
      end
      if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_after[%0d]: got valid=%b ready=%b want 0 1", n, obs_after_valid, obs_after_ready);
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_misalign();
    test_flush_drain();
    test_flush_misc();
    test_reset_midop();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
